micro_sequencer: RTL
====================

# micro_sequencer

Next-address generator for the microprogrammed control unit. Holds the control address register (CAR), selects the next microword address from the current microword's sequencing fields, the IR opcode and the ALU flags, and stalls or traps on memory waits. Drives the control-store address. The store returns the 32-bit control word and the sequencing fields for that address in the same cycle.

## Interface
- CAR_W, 8: control-store address width.
- FETCH_ADDR, 8'h00: reset and return-to-fetch address.
- TRAP_ADDR, 8'h7F: wait-timeout handler address.
- TIMEOUT, 15: maximum stall cycles before a trap.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ir_opcode  in  8  opcode from IR.
- uword_seq  in  2  sequencing mode of current microword: 00 INC, 01 JMP, 10 MAP, 11 RET.
- uword_cond  in  3  branch condition select, used by JMP.
- uword_next  in  CAR_W  branch target field.
- uword_wait  in  1  current microword must wait for mem_ready.
- uword_halt  in  1  current microword halts the sequencer.
- zf, cf, nf  in  1 each  ALU flags, registered by datapath.
- mem_ready  in  1  memory handshake completion.
- car  out  CAR_W  control-store address; reset FETCH_ADDR.
- cs_en  out  1  control word valid, datapath may act; reset 0.
- stall  out  1  high while waiting; reset 0.
- trap  out  1  one-cycle timeout pulse; reset 0.
- halted  out  1  sequencer halted; reset 0.

## Operation
- States:
  - RESET: one cycle after rst deasserts, cs_en=0.
  - RUN
  - WAIT
  - HALT
- RESET transitions to RUN unconditionally; car stays FETCH_ADDR.
- RUN, cs_en=1. Priority in RUN is halt > wait > sequencing.
  - uword_halt=1: car holds; go to HALT.
  - uword_wait=1 and mem_ready=0: car holds; go to WAIT; stall counter set to 1.
  - Otherwise the next car depends on uword_seq:
    - INC: car+1, modulo 2^CAR_W (8'hFF wraps to 8'h00).
    - JMP: uword_next if the condition is true, else car+1.
    - MAP: {1'b1, ir_opcode[4:0], 2'b00}. This gives 32 opcode routines of 4 microwords each in the upper half of the store. ir_opcode[7:5] is ignored.
    - RET: FETCH_ADDR.
- Conditions:
  - 000 always
  - 001 zf
  - 010 !zf
  - 011 cf
  - 100 !cf
  - 101 nf
  - 110 !nf
  - 111 never
- WAIT:
  - cs_en=0, stall=1, car holds. The microword is re-presented and the datapath must not re-execute side effects.
  - mem_ready=1: return to RUN. The counter clears. The held microword executes once with cs_en=1 in the following RUN cycle, where the wait is satisfied because mem_ready is sampled again.
  - Counter reaching TIMEOUT with mem_ready=0: car <= TRAP_ADDR, trap=1 for one cycle, counter clears, go to RUN.
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT: mem_ready wins, no trap.
- HALT: cs_en=0, halted=1, car holds. Only rst exits HALT.
- rst in any state, including mid-WAIT or HALT, forces RESET, car=FETCH_ADDR, counter 0, all flags 0, on the next edge.

## Timing
- car is registered. The next address is computed from the current cycle's uword_* and flag inputs and takes effect at the next rising edge.
- Fetch-decode latency: one cycle per microword, no bubbles in RUN.
- stall asserts in the cycle after the wait is detected. Minimum wait cost is 2 cycles (enter WAIT, return to RUN).
- trap rises in the same cycle car becomes TRAP_ADDR.
- All flags are sampled only in RUN. Flag changes during WAIT have no effect.

## Structure
- Shared package cu_pkg holds:
  - the seq-mode constants SEQ_INC, SEQ_JMP, SEQ_MAP, SEQ_RET;
  - the condition codes COND_*;
  - the state enum;
  - the map-function constant MAP_BASE = 8'h80.
- One natural sub-module: micro_cond_mux, a combinational condition select taking uword_cond and the flags and producing branch_taken.
- Stall counter width: $clog2(TIMEOUT+1).

## Test plan
- Reset release, INC everywhere -> RESET cycle with cs_en=0, then car 00,01,02,... one per cycle; with car=FF the next car is 00.
- JMP with cond=001, uword_next=8'h40: zf=1 -> car 40; zf=0 -> car+1. cond=111 never jumps.
- MAP with ir_opcode=8'hE5 -> car=8'h94. RET from 8'h95 -> car=00.
- uword_wait=1 with mem_ready low for 3 cycles then high -> stall high for 3 cycles, car unchanged, cs_en low, then resumes with car+1.
- mem_ready held low -> after TIMEOUT=15 stall cycles car=7F with one trap pulse; mem_ready rising on the 15th cycle -> no trap.
- uword_halt=1 -> halted=1 with car frozen through 10 cycles; rst asserted mid-WAIT and mid-HALT -> next cycle car=00, cs_en=0, stall=0, halted=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared control-unit definitions: sequencing modes, branch conditions,
// sequencer state encoding and the opcode map base.
package cu_pkg;

  // Sequencing modes carried in the microword
  localparam logic [1:0] SEQ_INC = 2'b00;
  localparam logic [1:0] SEQ_JMP = 2'b01;
  localparam logic [1:0] SEQ_MAP = 2'b10;
  localparam logic [1:0] SEQ_RET = 2'b11;

  // Branch condition selects used by JMP
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_ZF     = 3'b001;
  localparam logic [2:0] COND_NZF    = 3'b010;
  localparam logic [2:0] COND_CF     = 3'b011;
  localparam logic [2:0] COND_NCF    = 3'b100;
  localparam logic [2:0] COND_NF     = 3'b101;
  localparam logic [2:0] COND_NNF    = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // Opcode routines live in the upper half of the control store
  localparam logic [7:0] MAP_BASE = 8'h80;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_e;

  // 32 routines of 4 microwords each: base | opcode[4:0] << 2
  function automatic logic [7:0] map_addr(input logic [4:0] opcode_lo);
    return MAP_BASE | {1'b0, opcode_lo, 2'b00};
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Bundle between the sequencer and the control store / datapath.
// master = sequencer side, slave = store/datapath side.
interface micro_sequencer_if #(
  parameter int CAR_W = 8
);
  logic [7:0]       ir_opcode;
  logic [1:0]       uword_seq;
  logic [2:0]       uword_cond;
  logic [CAR_W-1:0] uword_next;
  logic             uword_wait;
  logic             uword_halt;
  logic             zf;
  logic             cf;
  logic             nf;
  logic             mem_ready;
  logic [CAR_W-1:0] car;
  logic             cs_en;
  logic             stall;
  logic             trap;
  logic             halted;

  modport master (
    input  ir_opcode, uword_seq, uword_cond, uword_next, uword_wait,
           uword_halt, zf, cf, nf, mem_ready,
    output car, cs_en, stall, trap, halted
  );

  modport slave (
    output ir_opcode, uword_seq, uword_cond, uword_next, uword_wait,
           uword_halt, zf, cf, nf, mem_ready,
    input  car, cs_en, stall, trap, halted
  );
endinterface

// File: rtl/micro_cond_mux.sv
// Branch condition select: picks a flag (or its inverse) for JMP.
module micro_cond_mux
  import cu_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_zf,
  input  logic       i_cf,
  input  logic       i_nf,
  output logic       o_branch_taken
);

  // Decode the condition select into a single taken bit
  always_comb begin
    o_branch_taken = 1'b0;
    case (i_cond)
      COND_ALWAYS: o_branch_taken = 1'b1;
      COND_ZF:     o_branch_taken = i_zf;
      COND_NZF:    o_branch_taken = ~i_zf;
      COND_CF:     o_branch_taken = i_cf;
      COND_NCF:    o_branch_taken = ~i_cf;
      COND_NF:     o_branch_taken = i_nf;
      COND_NNF:    o_branch_taken = ~i_nf;
      COND_NEVER:  o_branch_taken = 1'b0;
      default:     o_branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address generator for the microprogrammed control unit.
// Holds the CAR, sequences INC/JMP/MAP/RET, stalls on memory waits and
// traps to TRAP_ADDR when a wait exceeds TIMEOUT cycles.
module micro_sequencer
  import cu_pkg::*;
#(
  parameter int               CAR_W      = 8,
  parameter logic [CAR_W-1:0] FETCH_ADDR = 8'h00,
  parameter logic [CAR_W-1:0] TRAP_ADDR  = 8'h7F,
  parameter int               TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  micro_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [CAR_W-1:0] r_car;
  logic [CAR_W-1:0] w_car_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_trap;
  logic             w_trap_next;
  logic             w_branch_taken;
  logic [CAR_W-1:0] w_car_inc;
  logic [CAR_W-1:0] w_map_addr;

  micro_cond_mux u_cond_mux (
    .i_cond         (bus.uword_cond),
    .i_zf           (bus.zf),
    .i_cf           (bus.cf),
    .i_nf           (bus.nf),
    .o_branch_taken (w_branch_taken)
  );

  // Wraps naturally at 2^CAR_W
  assign w_car_inc  = r_car + CAR_W'(1);
  assign w_map_addr = CAR_W'(map_addr(bus.ir_opcode[4:0]));

  // State register; rst from any state lands in RESET
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // CAR, stall counter and trap pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_car  <= FETCH_ADDR;
      r_cnt  <= '0;
      r_trap <= 1'b0;
    end else begin
      r_car  <= w_car_next;
      r_cnt  <= w_cnt_next;
      r_trap <= w_trap_next;
    end
  end

  // Next state / next address; inputs are only consulted in RUN and WAIT
  always_comb begin
    w_state_next = r_state;
    w_car_next   = r_car;
    w_cnt_next   = r_cnt;
    w_trap_next  = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_next = ST_RUN;
        w_car_next   = FETCH_ADDR;
        w_cnt_next   = '0;
      end
      ST_RUN: begin
        if (bus.uword_halt) begin
          w_state_next = ST_HALT;
        end else if (bus.uword_wait && !bus.mem_ready) begin
          // The first stalled cycle counts as one
          w_state_next = ST_WAIT;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next = '0;
          case (bus.uword_seq)
            SEQ_INC: w_car_next = w_car_inc;
            SEQ_JMP: w_car_next = w_branch_taken ? bus.uword_next : w_car_inc;
            SEQ_MAP: w_car_next = w_map_addr;
            SEQ_RET: w_car_next = FETCH_ADDR;
            default: w_car_next = w_car_inc;
          endcase
        end
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          // Memory wins over a simultaneous timeout; the held microword
          // re-executes once in RUN with the wait satisfied
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = ST_RUN;
          w_car_next   = TRAP_ADDR;
          w_cnt_next   = '0;
          w_trap_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  // Moore outputs decoded from the state plus the registered trap pulse
  always_comb begin
    bus.car    = r_car;
    bus.cs_en  = (r_state == ST_RUN);
    bus.stall  = (r_state == ST_WAIT);
    bus.halted = (r_state == ST_HALT);
    bus.trap   = r_trap;
  end

endmodule
